// File: rtl/uart_pwm_ctrl.sv
// UART receiver feeding a two-byte command parser that programs a CH-channel PWM
// generator; duty updates are double-buffered and swapped only at counter wrap.
module uart_pwm_ctrl #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int CH     = 4,
  parameter int PW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RX,
  output logic [CH-1:0] pwm,
  output logic [1:0]    rate,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          cmd_ok
);

  localparam int BIT_CYC = (CLK_HZ / BAUD < 4) ? 4 : CLK_HZ / BAUD;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int HALF    = BIT_CYC / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic       {P_WAIT_HDR, P_WAIT_DATA} p_state_e;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q;
  logic [CW-1:0]   cyc_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q, rx_data_q;
  logic            rx_valid_q, frame_err_q;

  p_state_e              p_state_q;
  logic [2:0]            op_q;
  logic [3:0]            idx_q;
  logic [1:0]            rate_q;
  logic [5:0]            presc_q;
  logic [PW-1:0]         cnt_q;
  logic [CH-1:0][PW-1:0] duty_pend_q, duty_act_q;
  logic [CH-1:0]         pwm_q;
  logic                  cmd_ok_q;

  logic       rx_fall;
  logic       data_byte;
  logic       apply_duty, apply_rate;
  logic [5:0] presc_mask;
  logic       tick, wrap;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // Receive path: two-flop synchroniser, then a mid-bit sampling FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in clocked blocks so every flop sees pre-edge values.
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            cyc_q      <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cyc_q == CW'(HALF - 1)) begin
            cyc_q      <= '0;
            bit_q      <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cyc_q == CW'(BIT_CYC - 1)) begin
            cyc_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[7:1]};
            if (bit_q == 3'd7) rx_state_q <= RX_STOP;
            else               bit_q      <= bit_q + 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cyc_q == CW'(BIT_CYC - 1)) begin
            cyc_q      <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s2_q) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    presc_mask = 6'd0;
    case (rate_q)
      2'd0: presc_mask = 6'd0;
      2'd1: presc_mask = 6'd3;
      2'd2: presc_mask = 6'd15;
      2'd3: presc_mask = 6'd63;
      default: presc_mask = 6'd0;
    endcase
  end

  assign data_byte  = rx_valid_q && (p_state_q == P_WAIT_DATA);
  assign apply_duty = data_byte && (op_q == 3'd0) && (int'(idx_q) < CH);
  assign apply_rate = data_byte && (op_q == 3'd1);
  assign tick       = (presc_q & presc_mask) == presc_mask;
  assign wrap       = tick && (cnt_q == '1);

  // Command parser, prescaler and PWM datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state_q   <= P_WAIT_HDR;
      op_q        <= '0;
      idx_q       <= '0;
      rate_q      <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      pwm_q       <= '0;
      cmd_ok_q    <= 1'b0;
    end else begin
      cmd_ok_q <= 1'b0;
      if (frame_err_q) begin
        p_state_q <= P_WAIT_HDR;
      end else if (rx_valid_q) begin
        if (p_state_q == P_WAIT_HDR) begin
          if (rx_data_q[7]) begin
            op_q      <= rx_data_q[6:4];
            idx_q     <= rx_data_q[3:0];
            p_state_q <= P_WAIT_DATA;
          end
        end else begin
          p_state_q <= P_WAIT_HDR;
        end
      end

      if (apply_duty) begin
        for (int i = 0; i < CH; i++)
          if (idx_q == 4'(i)) duty_pend_q[i] <= PW'(rx_data_q);
        cmd_ok_q <= 1'b1;
      end
      if (apply_rate) begin
        rate_q   <= rx_data_q[1:0];
        cmd_ok_q <= 1'b1;
      end

      if (apply_rate && (rx_data_q[1:0] != rate_q)) presc_q <= '0;
      else                                         presc_q <= presc_q + 1'b1;

      if (tick) cnt_q <= cnt_q + 1'b1;
      // Swap takes the pre-edge pending value, so a same-cycle write waits a period.
      if (wrap) duty_act_q <= duty_pend_q;

      for (int i = 0; i < CH; i++)
        pwm_q[i] <= (cnt_q < duty_act_q[i]);
    end
  end

  assign pwm       = pwm_q;
  assign rate      = rate_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign cmd_ok    = cmd_ok_q;

endmodule

// File: tb/tb_uart_pwm_ctrl.sv
// Scoreboard bench for uart_pwm_ctrl: a byte-level command model queues the expected
// pulses, a negedge monitor pops them, and PWM duty is measured over whole periods.
module tb_uart_pwm_ctrl;
  localparam int CH  = 4;
  localparam int PW  = 8;
  localparam int BIT = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          RX = 1'b1;
  logic [CH-1:0] pwm;
  logic [1:0]    rate;
  logic [7:0]    rx_data;
  logic          rx_valid, frame_err, cmd_ok;

  uart_pwm_ctrl #(.CLK_HZ(16), .BAUD(1), .CH(CH), .PW(PW)) dut (
    .clk(clk), .reset(reset), .RX(RX), .pwm(pwm), .rate(rate),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .cmd_ok(cmd_ok)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_NONE, EV_RXV, EV_FERR, EV_CMD} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cmd_cyc = 0;
  int   hi_cnt[CH];

  // Reference model state: what the command stream has programmed so far.
  int         duty_m[CH];
  int         rate_m;
  bit         pend_m;
  int         op_m, idx_m;
  logic [7:0] last_m;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_e k, input int v, input string nm);
    ev_t e;
    e.kind = EV_NONE;
    e.val  = 0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({nm, "_kind"}, int'(k), int'(e.kind));
    if (e.kind == k) check({nm, "_val"}, v, e.val);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid)  expect_ev(EV_RXV, int'(rx_data), "rx_valid");
      if (frame_err) expect_ev(EV_FERR, int'(rx_data), "frame_err");
      if (cmd_ok) begin
        last_cmd_cyc = cyc;
        expect_ev(EV_CMD, int'(rate), "cmd_ok");
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < CH; i++) duty_m[i] = 0;
    rate_m = 0;
    pend_m = 1'b0;
    op_m   = 0;
    idx_m  = 0;
    last_m = 8'h00;
  endtask

  // Applies the protocol rules to one received byte and queues the pulses it implies.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      push_ev(EV_FERR, int'(last_m));
      pend_m = 1'b0;
    end else begin
      push_ev(EV_RXV, int'(b));
      last_m = b;
      if (!pend_m) begin
        if (b[7]) begin
          pend_m = 1'b1;
          op_m   = int'(b[6:4]);
          idx_m  = int'(b[3:0]);
        end
      end else begin
        pend_m = 1'b0;
        if (op_m == 0 && idx_m < CH) begin
          duty_m[idx_m] = int'(b);
          push_ev(EV_CMD, rate_m);
        end else if (op_m == 1) begin
          rate_m = int'(b[1:0]);
          push_ev(EV_CMD, rate_m);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    @(negedge clk) RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge clk);
    end
    RX = ok;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic count_window(input int len);
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    repeat (len) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) if (pwm[i]) hi_cnt[i]++;
    end
  endtask

  task automatic check_duties(input string tag);
    count_window(256);
    for (int i = 0; i < CH; i++)
      check($sformatf("%s_pwm%0d_high", tag, i), hi_cnt[i], duty_m[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm"}, int'(pwm), 0);
    check({tag, "_rate"}, int'(rate), 0);
    check({tag, "_rx_data"}, int'(rx_data), 0);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_cmd_ok"}, int'(cmd_ok), 0);
  endtask

  initial begin
    int         r, edges, hi2;
    logic       prev;
    logic [7:0] h, junk;

    model_reset();
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Plain byte, then a header killed by a framing error, then an orphan data byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h81, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h20, 1'b1);

    // Channel 2 to 64/256 at the fastest rate.
    send_byte(8'h82, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (300) @(negedge clk);
    check_duties("duty64");

    // Slowest rate: one count per 64 cycles, phase locked to the rate change.
    send_byte(8'h90, 1'b1);
    send_byte(8'h03, 1'b1);
    check("rate_out", int'(rate), rate_m);
    edges = 0;
    hi2   = 0;
    prev  = pwm[2];
    repeat (256 * 64) begin
      @(negedge clk);
      if (pwm[2]) hi2++;
      if (pwm[2] != prev) begin
        edges++;
        check("rate3_edge_phase", (cyc - last_cmd_cyc) % 64, 1);
      end
      prev = pwm[2];
    end
    check("rate3_pwm2_high", hi2, duty_m[2] * 64);
    check("rate3_edges", edges, 2);

    // Out-of-range channel is ignored; full-scale duty leaves one low count.
    send_byte(8'h90, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h87, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (600) @(negedge clk);
    check_duties("full");

    // Random command traffic with junk bytes and framing errors mixed in.
    for (int s = 0; s < 14; s++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        junk = 8'($urandom_range(0, 127));
        send_byte(junk, 1'b1);
      end else if (r == 1) begin
        junk = 8'($urandom);
        send_byte(junk, 1'b0);
      end else begin
        h = {1'b1, 3'($urandom_range(0, 2)), 4'($urandom_range(0, 5))};
        send_byte(h, 1'b1);
        junk = 8'($urandom);
        send_byte(junk, 1'b1);
      end
    end
    send_byte(8'h90, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (600) @(negedge clk);
    check_duties("random");

    // Short low glitch on the line must produce nothing.
    @(negedge clk) RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);

    // Reset while a header is pending and a byte is half received.
    send_byte(8'h82, 1'b1);
    @(negedge clk) RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = i[0];
      repeat (BIT) @(negedge clk);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    model_reset();
    RX = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h40, 1'b1);
    send_byte(8'hA5, 1'b1);
    check("post_reset_rx_data", int'(rx_data), 8'hA5);
    check_duties("post_reset");

    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
